// File: rtl/riscv_mc_pkg.sv
// Shared constants for the multi-cycle RISC-V control unit: opcodes,
// FSM state encoding, ALU operation codes and datapath mux selects.
package riscv_mc_pkg;

    // Opcodes as they appear in IR[6:0]
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    typedef enum logic [3:0] {
        ST_IDLE     = 4'd0,
        ST_FETCH    = 4'd1,
        ST_DECODE   = 4'd2,
        ST_MEM_ADDR = 4'd3,
        ST_MEM_RD   = 4'd4,
        ST_MEM_WB   = 4'd5,
        ST_MEM_WR   = 4'd6,
        ST_EXEC_R   = 4'd7,
        ST_EXEC_I   = 4'd8,
        ST_LUI      = 4'd9,
        ST_ALU_WB   = 4'd10,
        ST_BRANCH   = 4'd11,
        ST_JAL      = 4'd12,
        ST_FAULT    = 4'd13
    } state_t;

    // ALU operation codes
    localparam logic [2:0] ALU_ADD    = 3'b000;
    localparam logic [2:0] ALU_SUB    = 3'b001;
    localparam logic [2:0] ALU_PASSB  = 3'b010;
    localparam logic [2:0] ALU_RFUNCT = 3'b011;
    localparam logic [2:0] ALU_IFUNCT = 3'b100;

    // ALU operand A select
    localparam logic [1:0] SRC_A_PC    = 2'b00;
    localparam logic [1:0] SRC_A_RS1   = 2'b01;
    localparam logic [1:0] SRC_A_OLDPC = 2'b10;
    localparam logic [1:0] SRC_A_ZERO  = 2'b11;

    // ALU operand B select
    localparam logic [1:0] SRC_B_RS2  = 2'b00;
    localparam logic [1:0] SRC_B_FOUR = 2'b01;
    localparam logic [1:0] SRC_B_IMM  = 2'b10;

    // Register write-back source
    localparam logic [1:0] WB_ALUOUT = 2'b00;
    localparam logic [1:0] WB_MDR    = 2'b01;
    localparam logic [1:0] WB_PC     = 2'b10;

    // Fault cause encoding
    localparam logic CAUSE_ILLEGAL = 1'b0;
    localparam logic CAUSE_TIMEOUT = 1'b1;

    // States that hold a memory access open until Mem_Ready_i
    function automatic logic is_mem_wait(input state_t s);
        return (s == ST_FETCH) || (s == ST_MEM_RD) || (s == ST_MEM_WR);
    endfunction

endpackage

// File: rtl/mc_wait_timer.sv
// Memory wait-state timer. Counts consecutive not-ready cycles of one memory
// access and flags the cycle in which the access has used up its budget.
// Ports:
//   clk, reset  clock / asynchronous active-high reset
//   clear       restart the count (asserted on every state change)
//   enable      this cycle is a not-ready wait cycle
//   expired     enable is high and this is wait cycle number MEM_TIMEOUT
// MEM_TIMEOUT = 0 disables the timeout; expired is then tied low.
module mc_wait_timer #(
    parameter int MEM_TIMEOUT = 15
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    generate
        if (MEM_TIMEOUT > 0) begin : g_timeout
            localparam int CW = $clog2(MEM_TIMEOUT + 1);
            logic [CW-1:0] count;

            always_ff @(posedge clk or posedge reset) begin
                if (reset)       count <= '0;
                else if (clear)  count <= '0;
                else if (enable) count <= count + 1'b1;
            end

            // count holds the number of wait cycles already spent, so the
            // current one is the MEM_TIMEOUT-th when count == MEM_TIMEOUT-1
            assign expired = enable && (count == CW'(MEM_TIMEOUT - 1));
        end else begin : g_no_timeout
            assign expired = 1'b0;
        end
    endgenerate

endmodule

// File: rtl/multicycle_control.sv
// Moore control FSM for the multi-cycle RISC-V datapath (shared memory, IR,
// ALUOut). Sequences FETCH/DECODE/EXECUTE/MEM/WB per opcode, waits on the
// memory ready handshake with a bounded timeout, and parks in a sticky FAULT
// state on an illegal opcode or a memory timeout (left only through reset).
// Ports:
//   clk, reset        clock / asynchronous active-high reset
//   OP_i              opcode from IR
//   Mem_Ready_i       memory completes the access this cycle
//   PC_Write_o, PC_Write_Cond_o, PC_Src_o, IorD_o, Mem_Read_o, Mem_Write_o,
//   IR_Write_o, Mem_to_Reg_o, Reg_Write_o, ALU_Src_A_o, ALU_Src_B_o,
//   ALU_Op_o          datapath controls
//   Fault_o           sticky fault flag
//   Fault_Cause_o     0 = illegal opcode, 1 = memory timeout
// Optional feature: define MC_CTRL_JAL_EN to decode JAL (1101111); without it
// that opcode is illegal.
module multicycle_control
    import riscv_mc_pkg::*;
#(
    parameter int ALU_OP_WIDTH = 3,
    parameter int MEM_TIMEOUT  = 15
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [6:0]              OP_i,
    input  logic                    Mem_Ready_i,
    output logic                    PC_Write_o,
    output logic                    PC_Write_Cond_o,
    output logic                    PC_Src_o,
    output logic                    IorD_o,
    output logic                    Mem_Read_o,
    output logic                    Mem_Write_o,
    output logic                    IR_Write_o,
    output logic [1:0]              Mem_to_Reg_o,
    output logic                    Reg_Write_o,
    output logic [1:0]              ALU_Src_A_o,
    output logic [1:0]              ALU_Src_B_o,
    output logic [ALU_OP_WIDTH-1:0] ALU_Op_o,
    output logic                    Fault_o,
    output logic                    Fault_Cause_o
);

    state_t     state, state_next;
    logic       cause_q, cause_next;
    logic       wait_enable, wait_clear, wait_expired;
    logic [2:0] alu_op;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= ST_IDLE;
            cause_q <= 1'b0;
        end else begin
            state   <= state_next;
            cause_q <= cause_next;
        end
    end

    // Any state change restarts the wait budget, so each access gets its own
    assign wait_enable = is_mem_wait(state) && !Mem_Ready_i;
    assign wait_clear  = (state_next != state);

    mc_wait_timer #(
        .MEM_TIMEOUT(MEM_TIMEOUT)
    ) u_wait_timer (
        .clk     (clk),
        .reset   (reset),
        .clear   (wait_clear),
        .enable  (wait_enable),
        .expired (wait_expired)
    );

    // Next state. Ready is tested before expiry: a completing access wins
    // over a timeout in the same cycle.
    always_comb begin
        state_next = state;
        cause_next = cause_q;
        case (state)
            ST_IDLE: state_next = ST_FETCH;
            ST_FETCH: begin
                if (Mem_Ready_i) state_next = ST_DECODE;
                else if (wait_expired) begin
                    state_next = ST_FAULT;
                    cause_next = CAUSE_TIMEOUT;
                end
            end
            ST_DECODE: begin
                case (OP_i)
                    OP_LOAD, OP_STORE: state_next = ST_MEM_ADDR;
                    OP_RTYPE:          state_next = ST_EXEC_R;
                    OP_ITYPE:          state_next = ST_EXEC_I;
                    OP_BRANCH:         state_next = ST_BRANCH;
                    OP_LUI:            state_next = ST_LUI;
`ifdef MC_CTRL_JAL_EN
                    OP_JAL:            state_next = ST_JAL;
`endif
                    default: begin
                        state_next = ST_FAULT;
                        cause_next = CAUSE_ILLEGAL;
                    end
                endcase
            end
            ST_MEM_ADDR: begin
                // IR is stable here, so the opcode is simply looked at again;
                // an opcode that is no longer a load/store is treated as illegal
                if (OP_i == OP_STORE)     state_next = ST_MEM_WR;
                else if (OP_i == OP_LOAD) state_next = ST_MEM_RD;
                else begin
                    state_next = ST_FAULT;
                    cause_next = CAUSE_ILLEGAL;
                end
            end
            ST_MEM_RD, ST_MEM_WR: begin
                if (Mem_Ready_i)
                    state_next = (state == ST_MEM_RD) ? ST_MEM_WB : ST_FETCH;
                else if (wait_expired) begin
                    state_next = ST_FAULT;
                    cause_next = CAUSE_TIMEOUT;
                end
            end
            ST_EXEC_R, ST_EXEC_I, ST_LUI:                state_next = ST_ALU_WB;
            ST_MEM_WB, ST_ALU_WB, ST_BRANCH, ST_JAL:     state_next = ST_FETCH;
            ST_FAULT:                                    state_next = ST_FAULT;
            default:                                     state_next = ST_IDLE;
        endcase
    end

    // Output decode from state only; FETCH additionally gates the IR/PC loads
    // with Mem_Ready_i so they fire only when the instruction word is valid.
    always_comb begin
        PC_Write_o      = 1'b0;
        PC_Write_Cond_o = 1'b0;
        PC_Src_o        = 1'b0;
        IorD_o          = 1'b0;
        Mem_Read_o      = 1'b0;
        Mem_Write_o     = 1'b0;
        IR_Write_o      = 1'b0;
        Mem_to_Reg_o    = WB_ALUOUT;
        Reg_Write_o     = 1'b0;
        ALU_Src_A_o     = SRC_A_PC;
        ALU_Src_B_o     = SRC_B_RS2;
        alu_op          = ALU_ADD;
        case (state)
            ST_FETCH: begin
                Mem_Read_o  = 1'b1;
                ALU_Src_B_o = SRC_B_FOUR;
                IR_Write_o  = Mem_Ready_i;
                PC_Write_o  = Mem_Ready_i;
            end
            ST_DECODE: begin
                // Branch target precomputed into ALUOut
                ALU_Src_A_o = SRC_A_OLDPC;
                ALU_Src_B_o = SRC_B_IMM;
            end
            ST_MEM_ADDR: begin
                ALU_Src_A_o = SRC_A_RS1;
                ALU_Src_B_o = SRC_B_IMM;
            end
            ST_MEM_RD: begin
                IorD_o     = 1'b1;
                Mem_Read_o = 1'b1;
            end
            ST_MEM_WB: begin
                Reg_Write_o  = 1'b1;
                Mem_to_Reg_o = WB_MDR;
            end
            ST_MEM_WR: begin
                IorD_o      = 1'b1;
                Mem_Write_o = 1'b1;
            end
            ST_EXEC_R: begin
                ALU_Src_A_o = SRC_A_RS1;
                ALU_Src_B_o = SRC_B_RS2;
                alu_op      = ALU_RFUNCT;
            end
            ST_EXEC_I: begin
                ALU_Src_A_o = SRC_A_RS1;
                ALU_Src_B_o = SRC_B_IMM;
                alu_op      = ALU_IFUNCT;
            end
            ST_LUI: begin
                ALU_Src_A_o = SRC_A_ZERO;
                ALU_Src_B_o = SRC_B_IMM;
                alu_op      = ALU_PASSB;
            end
            ST_ALU_WB: begin
                Reg_Write_o  = 1'b1;
                Mem_to_Reg_o = WB_ALUOUT;
            end
            ST_BRANCH: begin
                ALU_Src_A_o     = SRC_A_RS1;
                ALU_Src_B_o     = SRC_B_RS2;
                alu_op          = ALU_SUB;
                PC_Write_Cond_o = 1'b1;
                PC_Src_o        = 1'b1;
            end
            ST_JAL: begin
                // Jump target already in ALUOut from DECODE; rd gets PC+4
                PC_Write_o   = 1'b1;
                PC_Src_o     = 1'b1;
                Reg_Write_o  = 1'b1;
                Mem_to_Reg_o = WB_PC;
            end
            default: ;
        endcase
    end

    assign ALU_Op_o      = ALU_OP_WIDTH'(alu_op);
    assign Fault_o       = (state == ST_FAULT);
    assign Fault_Cause_o = cause_q;

endmodule
